// File: rtl/ddr3_word_bridge_pkg.sv
// ddr3_word_bridge_pkg
//   Shared widths and tracking-FIFO entry layout for ddr3_word_bridge.
//   Entry layout (LSB first): IS_WR (1 bit), LANE (2 bits), ID (ID_W bits).
package ddr3_word_bridge_pkg;

    localparam int LANE_W     = 32;   // upstream word width
    localparam int LINE_W     = 128;  // ddr3_core line width
    localparam int MASK_W     = 16;   // line byte-strobe width
    localparam int LANE_SEL_W = 2;    // addr[3:2]

    // Tracking FIFO entry field offsets
    localparam int ENT_IS_WR    = 0;
    localparam int ENT_LANE_LSB = 1;
    localparam int ENT_ID_LSB   = ENT_LANE_LSB + LANE_SEL_W;

endpackage

// File: rtl/ddr3_word_bridge_fifo.sv
// ddr3_word_bridge_fifo
//   Synchronous in-order FIFO tracking outstanding requests.
//   Ports:
//     clk_i, rst_i      clock, synchronous active-high reset
//     push_i, data_i    write an entry (accepted when not full, or when full
//                       together with a pop on the same edge)
//     pop_i             drop the head entry (ignored when empty)
//     data_o            head entry (valid while !empty_o)
//     full_o, empty_o   occupancy flags
module ddr3_word_bridge_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 19
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    // A pop frees the slot the push lands in, so push is fine when full.
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointers wrap naturally.
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/ddr3_word_bridge.sv
// ddr3_word_bridge
//   Converts a 32-bit word request port into ddr3_core's 128-bit line
//   request/response interface. Each word is steered to lane addr[3:2] with a
//   shifted byte mask; outstanding requests are tracked in an in-order FIFO so
//   read responses can be lane-extracted and response IDs checked.
//   Ports:
//     clk_i, rst_i             clock, synchronous active-high reset
//     inport_*                 upstream 32-bit word request/response port
//     outport_*                downstream 128-bit ddr3_core port (registered
//                              request, 1-cycle latency, held until accept)
//     stat_reads_o/writes_o    completed reads / writes (wrapping)
//     stat_spurious_o          acks seen with nothing outstanding (saturating)
//   Build option: define DDR3_WORD_BRIDGE_STATS_EN to instantiate the stat
//   counters; otherwise the stat ports are tied to 0.
module ddr3_word_bridge
    import ddr3_word_bridge_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ID_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [3:0]        inport_wr_i,
    input  logic              inport_rd_i,
    input  logic [31:0]       inport_addr_i,
    input  logic [31:0]       inport_write_data_i,
    input  logic [ID_W-1:0]   inport_req_id_i,
    output logic              inport_accept_o,
    output logic              inport_ack_o,
    output logic              inport_error_o,
    output logic [ID_W-1:0]   inport_resp_id_o,
    output logic [31:0]       inport_read_data_o,
    output logic [MASK_W-1:0] outport_wr_o,
    output logic              outport_rd_o,
    output logic [31:0]       outport_addr_o,
    output logic [LINE_W-1:0] outport_write_data_o,
    output logic [ID_W-1:0]   outport_req_id_o,
    input  logic              outport_accept_i,
    input  logic              outport_ack_i,
    input  logic              outport_error_i,
    input  logic [ID_W-1:0]   outport_resp_id_i,
    input  logic [LINE_W-1:0] outport_read_data_i,
    output logic [31:0]       stat_reads_o,
    output logic [31:0]       stat_writes_o,
    output logic [15:0]       stat_spurious_o
);

    localparam int ENT_W = ENT_ID_LSB + ID_W;

    logic                  is_wr, req, xfer, pop;
    logic                  fifo_full, fifo_empty;
    logic [LANE_SEL_W-1:0] lane;
    logic [ENT_W-1:0]      push_ent, head_ent;
    logic                  head_is_wr;
    logic [LANE_SEL_W-1:0] head_lane;
    logic [ID_W-1:0]       head_id;

    // Output (request) register
    logic              out_valid_q, out_valid_d;
    logic [MASK_W-1:0] out_wr_q,    out_wr_d;
    logic              out_rd_q,    out_rd_d;
    logic [31:0]       out_addr_q,  out_addr_d;
    logic [LANE_W-1:0] out_data_q,  out_data_d;
    logic [ID_W-1:0]   out_id_q,    out_id_d;

    // Response register
    logic              ack_q,   ack_d;
    logic              err_q,   err_d;
    logic [ID_W-1:0]   rid_q,   rid_d;
    logic [LANE_W-1:0] rdata_q, rdata_d;

    logic unused_addr_bits;
    assign unused_addr_bits = ^inport_addr_i[1:0];

    // Any strobe makes it a write; rd is ignored in that case.
    assign is_wr = |inport_wr_i;
    assign req   = inport_rd_i | is_wr;
    assign lane  = inport_addr_i[3:2];

    // FIFO occupancy already counts the request sitting in the output register.
    // Held low during reset so no output is asserted while rst_i is high.
    assign inport_accept_o = ~rst_i & (~out_valid_q | outport_accept_i) & ~fifo_full;
    assign xfer            = req & inport_accept_o;
    assign pop             = outport_ack_i & ~fifo_empty;

    always_comb begin
        push_ent = '0;
        push_ent[ENT_IS_WR]                    = is_wr;
        push_ent[ENT_LANE_LSB +: LANE_SEL_W]   = lane;
        push_ent[ENT_ID_LSB +: ID_W]           = inport_req_id_i;
    end

    assign head_is_wr = head_ent[ENT_IS_WR];
    assign head_lane  = head_ent[ENT_LANE_LSB +: LANE_SEL_W];
    assign head_id    = head_ent[ENT_ID_LSB +: ID_W];

    ddr3_word_bridge_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (xfer),
        .data_i  (push_ent),
        .pop_i   (pop),
        .data_o  (head_ent),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_wr_d    = out_wr_q;
        out_rd_d    = out_rd_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_wr_d    = is_wr ? (MASK_W'(inport_wr_i) << {lane, 2'b00}) : '0;
            out_rd_d    = ~is_wr;
            out_addr_d  = {inport_addr_i[31:4], 4'b0000};
            out_data_d  = inport_write_data_i;
            out_id_d    = inport_req_id_i;
        end else if (outport_accept_i) begin
            // Drop the strobes so ddr3_core sees no request once taken.
            out_valid_d = 1'b0;
            out_wr_d    = '0;
            out_rd_d    = 1'b0;
        end
    end

    always_comb begin
        ack_d   = pop;
        err_d   = pop & (outport_error_i | (outport_resp_id_i != head_id));
        rid_d   = pop ? head_id : '0;
        rdata_d = (pop & ~head_is_wr) ? outport_read_data_i[LANE_W*head_lane +: LANE_W] : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_wr_q    <= '0;
            out_rd_q    <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rid_q       <= '0;
            rdata_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_wr_q    <= out_wr_d;
            out_rd_q    <= out_rd_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rid_q       <= rid_d;
            rdata_q     <= rdata_d;
        end
    end

    assign outport_wr_o         = out_wr_q;
    assign outport_rd_o         = out_rd_q;
    assign outport_addr_o       = out_addr_q;
    assign outport_write_data_o = {4{out_data_q}};
    assign outport_req_id_o     = out_id_q;
    assign inport_ack_o         = ack_q;
    assign inport_error_o       = err_q;
    assign inport_resp_id_o     = rid_q;
    assign inport_read_data_o   = rdata_q;

`ifdef DDR3_WORD_BRIDGE_STATS_EN
    logic [31:0] stat_reads_q, stat_reads_d;
    logic [31:0] stat_writes_q, stat_writes_d;
    logic [15:0] stat_spur_q, stat_spur_d;

    always_comb begin
        stat_reads_d  = stat_reads_q;
        stat_writes_d = stat_writes_q;
        stat_spur_d   = stat_spur_q;
        if (pop & ~head_is_wr) stat_reads_d  = stat_reads_q + 32'd1;
        if (pop &  head_is_wr) stat_writes_d = stat_writes_q + 32'd1;
        if (outport_ack_i & fifo_empty & (stat_spur_q != 16'hFFFF))
            stat_spur_d = stat_spur_q + 16'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_reads_q  <= '0;
            stat_writes_q <= '0;
            stat_spur_q   <= '0;
        end else begin
            stat_reads_q  <= stat_reads_d;
            stat_writes_q <= stat_writes_d;
            stat_spur_q   <= stat_spur_d;
        end
    end

    assign stat_reads_o    = stat_reads_q;
    assign stat_writes_o   = stat_writes_q;
    assign stat_spurious_o = stat_spur_q;
`else
    assign stat_reads_o    = '0;
    assign stat_writes_o   = '0;
    assign stat_spurious_o = '0;
`endif

endmodule

// File: tb/tb_ddr3_word_bridge.sv
module tb_ddr3_word_bridge;

    localparam int DEPTH = 4;
    localparam int ID_W  = 16;
`ifdef DDR3_WORD_BRIDGE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_i = 1'b1;
    logic [3:0]       inport_wr_i = '0;
    logic             inport_rd_i = 1'b0;
    logic [31:0]      inport_addr_i = '0;
    logic [31:0]      inport_write_data_i = '0;
    logic [ID_W-1:0]  inport_req_id_i = '0;
    logic             inport_accept_o, inport_ack_o, inport_error_o;
    logic [ID_W-1:0]  inport_resp_id_o;
    logic [31:0]      inport_read_data_o;
    logic [15:0]      outport_wr_o;
    logic             outport_rd_o;
    logic [31:0]      outport_addr_o;
    logic [127:0]     outport_write_data_o;
    logic [ID_W-1:0]  outport_req_id_o;
    logic             outport_accept_i = 1'b0;
    logic             outport_ack_i = 1'b0;
    logic             outport_error_i = 1'b0;
    logic [ID_W-1:0]  outport_resp_id_i = '0;
    logic [127:0]     outport_read_data_i = '0;
    logic [31:0]      stat_reads_o, stat_writes_o;
    logic [15:0]      stat_spurious_o;

    ddr3_word_bridge #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .inport_wr_i(inport_wr_i), .inport_rd_i(inport_rd_i),
        .inport_addr_i(inport_addr_i), .inport_write_data_i(inport_write_data_i),
        .inport_req_id_i(inport_req_id_i), .inport_accept_o(inport_accept_o),
        .inport_ack_o(inport_ack_o), .inport_error_o(inport_error_o),
        .inport_resp_id_o(inport_resp_id_o), .inport_read_data_o(inport_read_data_o),
        .outport_wr_o(outport_wr_o), .outport_rd_o(outport_rd_o),
        .outport_addr_o(outport_addr_o), .outport_write_data_o(outport_write_data_o),
        .outport_req_id_o(outport_req_id_o), .outport_accept_i(outport_accept_i),
        .outport_ack_i(outport_ack_i), .outport_error_i(outport_error_i),
        .outport_resp_id_i(outport_resp_id_i), .outport_read_data_i(outport_read_data_i),
        .stat_reads_o(stat_reads_o), .stat_writes_o(stat_writes_o),
        .stat_spurious_o(stat_spurious_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- ddr3_core stand-in: 16 lines of 128 bits ----------------
    typedef struct { logic [ID_W-1:0] id; logic [127:0] data; } rsp_t;
    logic [127:0] line_mem [16] = '{default: '0};
    rsp_t rsp_q[$];
    bit ds_accept = 1'b1, ds_ack_en = 1'b1, ds_rand = 1'b0;
    int spur_req = 0, spur_done = 0, bump_req = 0, bump_done = 0;

    always @(posedge clk) begin
        if (outport_accept_i && (outport_rd_o || outport_wr_o != 16'h0)) begin
            for (int b = 0; b < 16; b++)
                if (outport_wr_o[b])
                    line_mem[outport_addr_o[7:4]][8*b +: 8] = outport_write_data_o[8*b +: 8];
            rsp_q.push_back('{outport_req_id_o, line_mem[outport_addr_o[7:4]]});
        end
    end

    always @(negedge clk) begin
        rsp_t r;
        outport_accept_i    = ds_accept && (!ds_rand || $urandom_range(0, 3) != 0);
        outport_ack_i       = 1'b0;
        outport_error_i     = 1'b0;
        outport_resp_id_i   = '0;
        outport_read_data_i = '0;
        if (spur_done < spur_req) begin
            outport_ack_i     = 1'b1;
            outport_resp_id_i = 16'h7777;
            spur_done++;
        end else if (ds_ack_en && rsp_q.size() > 0 && (!ds_rand || $urandom_range(0, 3) != 0)) begin
            r = rsp_q.pop_front();
            outport_ack_i       = 1'b1;
            outport_resp_id_i   = r.id;
            outport_read_data_i = r.data;
            if (bump_done < bump_req) begin
                outport_resp_id_i = r.id + 16'd1;
                bump_done++;
            end
        end
    end

    // ---------------- reference model: word-addressed memory + expected queue ----------------
    typedef struct { logic [ID_W-1:0] id; logic [31:0] data; logic err; bit is_wr; } exp_t;
    typedef struct { logic [ID_W-1:0] id; logic [31:0] data; logic err; } got_t;
    logic [31:0] ref_mem [64] = '{default: '0};
    exp_t exp_q[$];
    got_t got_q[$];
    int tot_reads = 0, tot_writes = 0;

    always @(negedge clk)
        if (inport_ack_o) got_q.push_back('{inport_resp_id_o, inport_read_data_o, inport_error_o});

    // Called at posedge+#1; returns at posedge+#1.
    task automatic issue(input logic [3:0] wr, input logic rd, input logic [31:0] addr,
                         input logic [31:0] data, input logic [ID_W-1:0] id,
                         input int max_wait, output bit acc);
        int n = 0;
        inport_wr_i = wr; inport_rd_i = rd; inport_addr_i = addr;
        inport_write_data_i = data; inport_req_id_i = id;
        @(negedge clk); #1;
        while (!inport_accept_o && n < max_wait) begin
            @(negedge clk); #1;
            n++;
        end
        acc = inport_accept_o;
        @(posedge clk); #1;
        inport_wr_i = '0; inport_rd_i = 1'b0;
        if (acc) begin
            if (wr != 4'h0) begin
                for (int b = 0; b < 4; b++)
                    if (wr[b]) ref_mem[addr[7:2]][8*b +: 8] = data[8*b +: 8];
                exp_q.push_back('{id, 32'h0, 1'b0, 1'b1});
            end else begin
                exp_q.push_back('{id, ref_mem[addr[7:2]], 1'b0, 1'b0});
            end
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        exp_t e;
        got_t g;
        while (got_q.size() < exp_q.size() && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            if (e.is_wr) tot_writes++; else tot_reads++;
            chk({tag, "_id"},   g.id,   e.id);
            chk({tag, "_data"}, g.data, e.data);
            chk({tag, "_err"},  g.err,  e.err);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int nacc;
        logic [3:0] st;
        logic rd;

        // ---- reset ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", {inport_ack_o, inport_error_o, inport_resp_id_o, inport_read_data_o}, '0);
        chk("rst_accept", inport_accept_o, 1'b0);
        chk("rst_out", {outport_wr_o, outport_rd_o, outport_addr_o, outport_req_id_o}, '0);
        chk("rst_wdata", outport_write_data_o, '0);
        chk("rst_stats", {stat_reads_o, stat_writes_o, stat_spurious_o}, '0);
        @(posedge clk); #1;
        rst_i = 1'b0;

        // ---- full-word write to lane 1, then read back ----
        issue(4'hF, 1'b0, 32'h24, 32'hDEADBEEF, 16'h0001, 5, acc);
        chk("wl_acc", acc, 1'b1);
        chk("wl_addr", outport_addr_o, 32'h20);
        chk("wl_mask", outport_wr_o, 16'h00F0);
        chk("wl_rd", outport_rd_o, 1'b0);
        chk("wl_wdata", outport_write_data_o, {4{32'hDEADBEEF}});
        issue(4'h0, 1'b1, 32'h24, 32'h0, 16'h0002, 5, acc);
        chk("rl_rd", {outport_rd_o, outport_wr_o, outport_req_id_o}, {1'b1, 16'h0, 16'h0002});
        drain("wl");

        // ---- partial strobe on lane 3 ----
        issue(4'b0110, 1'b0, 32'h1C, 32'h11223344, 16'h0003, 5, acc);
        chk("ps_mask", outport_wr_o, 16'h6000);
        issue(4'h0, 1'b1, 32'h1C, 32'h0, 16'h0013, 5, acc);
        // rd together with strobes is a write
        issue(4'h1, 1'b1, 32'h00, 32'h000000A5, 16'h0023, 5, acc);
        chk("rw_is_wr", {outport_rd_o, outport_wr_o}, {1'b0, 16'h0001});
        drain("ps");

        // ---- fill line 0x20 ----
        issue(4'hF, 1'b0, 32'h20, 32'hA0A0A0A0, 16'h0030, 5, acc);
        issue(4'hF, 1'b0, 32'h28, $urandom, 16'h0031, 5, acc);
        issue(4'hF, 1'b0, 32'h2C, $urandom, 16'h0032, 5, acc);
        drain("fill");

        // ---- downstream accept withheld: register holds ----
        @(posedge clk); #1; ds_accept = 1'b0;
        issue(4'h0, 1'b1, 32'h28, 32'h0, 16'h000A, 3, acc);
        chk("bpa_first", acc, 1'b1);
        issue(4'h0, 1'b1, 32'h2C, 32'h0, 16'h000B, 3, acc);
        chk("bpa_second", acc, 1'b0);
        chk("bpa_hold", {outport_rd_o, outport_addr_o, outport_req_id_o}, {1'b1, 32'h20, 16'h000A});
        ds_accept = 1'b1;
        drain("bpa");

        // ---- acks withheld: FIFO fills at DEPTH ----
        ds_ack_en = 1'b0;
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            issue(4'h0, 1'b1, 32'h20 + 32'(4 * (i % 4)), 32'h0, 16'(16'h0020 + i), 2, acc);
            if (acc) nacc++;
        end
        chk("bpb_naccept", nacc, DEPTH);
        @(negedge clk); #1;
        chk("bpb_accept_lo", inport_accept_o, 1'b0);
        @(posedge clk); #1;
        ds_ack_en = 1'b1;
        drain("bpb");

        // ---- ID mismatch ----
        bump_req++;
        issue(4'h0, 1'b1, 32'h24, 32'h0, 16'h0004, 5, acc);
        exp_q[exp_q.size()-1].err = 1'b1;
        drain("idm");

        // ---- spurious ack ----
        spur_req++;
        repeat (4) @(posedge clk);
        #1;
        chk("spur_noack", got_q.size(), 0);
        chk("spur_stat", stat_spurious_o, STATS ? 16'd1 : 16'd0);

        // ---- randomized traffic ----
        ds_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rd = 1'($urandom_range(0, 1));
            st = rd ? 4'h0 : 4'($urandom_range(1, 15));
            issue(st, rd, 32'($urandom_range(0, 255)), $urandom, 16'($urandom), 60, acc);
            chk("rnd_acc", acc, 1'b1);
        end
        ds_rand = 1'b0;
        drain("rnd");
        chk("stat_reads", stat_reads_o, STATS ? 32'(tot_reads) : 32'd0);
        chk("stat_writes", stat_writes_o, STATS ? 32'(tot_writes) : 32'd0);

        // ---- reset with two requests in flight ----
        ds_ack_en = 1'b0;
        issue(4'h0, 1'b1, 32'h24, 32'h0, 16'h0040, 5, acc);
        issue(4'h0, 1'b1, 32'h28, 32'h0, 16'h0041, 5, acc);
        exp_q.delete();
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mrst_ack", {inport_ack_o, inport_error_o, inport_resp_id_o, inport_read_data_o}, '0);
        chk("mrst_out", {outport_wr_o, outport_rd_o, outport_addr_o, outport_req_id_o}, '0);
        chk("mrst_stats", {stat_reads_o, stat_writes_o, stat_spurious_o}, '0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        ds_ack_en = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("mrst_noack", got_q.size(), 0);
        chk("mrst_spur", stat_spurious_o, STATS ? 16'd2 : 16'd0);

        // ---- normal service after reset ----
        issue(4'hF, 1'b0, 32'h38, 32'hCAFEF00D, 16'h0050, 5, acc);
        issue(4'h0, 1'b1, 32'h38, 32'h0, 16'h0051, 5, acc);
        drain("post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
